pio_stream_loader: RTL and testbench

//  Byte-stream front end for the pio block: assembles 6-byte command frames (e.g. from a UART RX) and

---
 rtl/pio_pkg.sv | 26 ++
 rtl/pio_frame_timeout.sv | 36 +++
 rtl/pio_stream_loader.sv | 141 ++++++++++++++
 tb/tb_pio_stream_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_pkg.sv
// pio_pkg
//   Shared definitions for the pio command path: action codes, the stream
//   frame length and the frame-assembly FSM state encoding.
package pio_pkg;

  localparam logic [3:0] ACT_NOP   = 4'h0;
  localparam logic [3:0] ACT_INSTR = 4'h1;
  localparam logic [3:0] ACT_END   = 4'hF;

  localparam int FRAME_LEN = 6;

  localparam logic [2:0] ST_HDR   = 3'd0;
  localparam logic [2:0] ST_IDX   = 3'd1;
  localparam logic [2:0] ST_D0    = 3'd2;
  localparam logic [2:0] ST_D1    = 3'd3;
  localparam logic [2:0] ST_D2    = 3'd4;
  localparam logic [2:0] ST_D3    = 3'd5;
  localparam logic [2:0] ST_ISSUE = 3'd6;

  // NOP and END frames are consumed by the loader itself; everything else
  // goes out on the pio command bus.
  function automatic logic act_issues(input logic [3:0] act);
    return (act != ACT_NOP) && (act != ACT_END);
  endfunction

endpackage

// File: rtl/pio_frame_timeout.sv
// pio_frame_timeout
//   Inter-byte idle counter for the stream loader. Counts enabled cycles and
//   raises expire combinationally on the enabled cycle that would reach
//   TIMEOUT_CYC; the count clears itself on that same edge.
// Ports
//   clk     in   clock
//   reset   in   synchronous active-high reset
//   clr     in   clear the count (handshake, or not inside a frame)
//   en      in   count this cycle (inside a frame, no handshake)
//   expire  out  this cycle completes TIMEOUT_CYC idle cycles
module pio_frame_timeout #(
  parameter int TIMEOUT_CYC = 250000,
  parameter int TO_W        = 18
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] cnt;

  assign expire = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/pio_stream_loader.sv
// pio_stream_loader
//   Byte-stream front end for pio. Assembles 6-byte command frames
//   (B0={act,mi,00}, B1={xxx,idx}, B2..B5=din LSB first) and issues each as a
//   one-cycle command on the pio action/mindex/index/din bus. NOP frames are
//   dropped, END frames set the sticky done flag. A frame stalled between
//   bytes for TIMEOUT_CYC cycles is discarded with a one-cycle err pulse.
// Ports
//   clk        in   clock shared with pio
//   reset      in   synchronous active-high reset
//   in_data    in   stream byte
//   in_valid   in   in_data valid
//   in_ready   out  byte accepted when in_valid & in_ready
//   action     out  pio action, non-zero for one cycle per issued frame
//   mindex     out  pio machine index (held until next issue)
//   index      out  pio instruction/register index (held until next issue)
//   din        out  pio data word (held until next issue)
//   done       out  sticky, set by an END frame
//   err        out  one-cycle pulse on frame timeout
//   frame_cnt  out  number of issued frames, wraps at 256
module pio_stream_loader
  import pio_pkg::*;
#(
  parameter int TIMEOUT_CYC = 250000,
  parameter int TO_W        = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  output logic [4:0]  index,
  output logic [31:0] din,
  output logic        done,
  output logic        err,
  output logic [7:0]  frame_cnt
);

  logic [2:0]  state;
  logic [3:0]  act_p0;
  logic [1:0]  mi_p0;
  logic [4:0]  idx_p0;
  logic [31:0] din_p0;
  logic        vld_p0;
  logic        hs;
  logic        in_frame;
  logic        to_expire;

  assign in_ready = (state != ST_ISSUE);
  assign hs       = in_valid && in_ready;
  assign in_frame = (state >= ST_IDX) && (state <= ST_D3);
  assign vld_p0   = (state == ST_ISSUE);

  pio_frame_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_frame || hs),
    .en     (in_frame && !hs),
    .expire (to_expire)
  );

  // ---- stage p0: byte capture and frame sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_HDR;
      act_p0 <= '0;
      mi_p0  <= '0;
      idx_p0 <= '0;
      din_p0 <= '0;
      err    <= 1'b0;
    end else begin
      // The timeout only fires on a cycle without a handshake, so the two
      // branches below never compete.
      err <= to_expire;
      if (to_expire) begin
        state <= ST_HDR;
      end else if (hs) begin
        case (state)
          ST_HDR: begin
            act_p0 <= in_data[7:4];
            mi_p0  <= in_data[3:2];
            state  <= ST_IDX;
          end
          ST_IDX: begin
            idx_p0 <= in_data[4:0];
            state  <= ST_D0;
          end
          ST_D0: begin
            din_p0[7:0] <= in_data;
            state       <= ST_D1;
          end
          ST_D1: begin
            din_p0[15:8] <= in_data;
            state        <= ST_D2;
          end
          ST_D2: begin
            din_p0[23:16] <= in_data;
            state         <= ST_D3;
          end
          ST_D3: begin
            din_p0[31:24] <= in_data;
            state         <= ST_ISSUE;
          end
          default: state <= ST_HDR;
        endcase
      end else if (vld_p0) begin
        state <= ST_HDR;
      end
    end
  end

  // ---- stage p1: command issue onto the pio bus
  always_ff @(posedge clk) begin
    if (reset) begin
      action    <= ACT_NOP;
      mindex    <= '0;
      index     <= '0;
      din       <= '0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      action <= ACT_NOP;
      if (vld_p0) begin
        if (act_issues(act_p0)) begin
          action    <= act_p0;
          mindex    <= mi_p0;
          index     <= idx_p0;
          din       <= din_p0;
          frame_cnt <= frame_cnt + 8'd1;
        end else if (act_p0 == ACT_END) begin
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_stream_loader.sv
module tb_pio_stream_loader;
  import pio_pkg::*;

  localparam int T = 40;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  action;
  logic [1:0]  mindex;
  logic [4:0]  index;
  logic [31:0] din;
  logic        done;
  logic        err;
  logic [7:0]  frame_cnt;

  pio_stream_loader #(.TIMEOUT_CYC(T), .TO_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .action    (action),
    .mindex    (mindex),
    .index     (index),
    .din       (din),
    .done      (done),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  act;
    logic [1:0]  mi;
    logic [4:0]  idx;
    logic [31:0] d;
    int          due;
  } rec_t;

  rec_t       q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         err_due = -1;
  int         ready_waits = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic       exp_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // One clock: advance to the next falling edge and compare every output
  // against the frame-level model.
  task automatic tick();
    rec_t       r;
    logic [3:0] exp_act;
    @(negedge clk);
    cyc++;
    exp_act = ACT_NOP;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.act == ACT_END) begin
        exp_done = 1'b1;
      end else if (r.act != ACT_NOP) begin
        exp_act = r.act;
        exp_cnt = exp_cnt + 8'd1;
        chk("mindex", 64'(mindex), 64'(r.mi));
        chk("index", 64'(index), 64'(r.idx));
        chk("din", 64'(din), 64'(r.d));
      end
    end
    chk("action", 64'(action), 64'(exp_act));
    chk("frame_cnt", 64'(frame_cnt), 64'(exp_cnt));
    chk("done", 64'(done), 64'(exp_done));
    chk("err", 64'(err), 64'(cyc == err_due));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    q.delete();
    exp_cnt = 8'd0;
    exp_done = 1'b0;
    err_due = -1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_action"}, 64'(action), 64'(0));
    chk({tag, "_mindex"}, 64'(mindex), 64'(0));
    chk({tag, "_index"}, 64'(index), 64'(0));
    chk({tag, "_din"}, 64'(din), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    in_data = b;
    in_valid = 1'b1;
    while (!in_ready && w < 8) begin
      tick();
      w++;
    end
    ready_waits += w;
    chk("ready_bound", 64'(in_ready), 64'(1));
    tick();
  endtask

  // gap < 0: random idle cycles before each byte, occasionally the longest
  // gap that still beats the timeout.
  task automatic send_frame(input logic [3:0] act, input logic [1:0] mi, input logic [4:0] idx,
                            input logic [31:0] d, input int nbytes, input int gap);
    logic [7:0] b[FRAME_LEN];
    int         g;
    b[0] = {act, mi, 2'b00};
    b[1] = {3'($urandom), idx};
    for (int k = 0; k < 4; k++) b[2+k] = d[8*k +: 8];
    for (int k = 0; k < nbytes; k++) begin
      if (gap >= 0) g = gap;
      else g = ($urandom_range(0, 7) == 0) ? T - 1 : int'($urandom_range(0, 3));
      if (g > 0) begin
        in_valid = 1'b0;
        for (int i = 0; i < g; i++) begin
          in_data = 8'($urandom);
          tick();
        end
      end
      send_byte(b[k]);
    end
    in_valid = 1'b0;
    if (nbytes == FRAME_LEN) q.push_back('{act, mi, idx, d, cyc + 1});
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    do_reset();
    chk_reset_state("rst");

    // Single INSTR frame: latency, field mapping, one-cycle action.
    send_frame(ACT_INSTR, 2'd0, 5'd3, 32'hDDCCBBAA, FRAME_LEN, 0);
    chk("t1_issue_ready", 64'(in_ready), 64'(0));
    chk("t1_issue_action", 64'(action), 64'(0));
    tick();
    chk("t1_action", 64'(action), 64'(1));
    chk("t1_index", 64'(index), 64'(3));
    chk("t1_din", 64'(din), 64'(32'hDDCCBBAA));
    chk("t1_frame_cnt", 64'(frame_cnt), 64'(1));
    tick();
    chk("t1_action_off", 64'(action), 64'(0));

    // Back-to-back frames with in_valid held high.
    do_reset();
    ready_waits = 0;
    for (int k = 0; k < 31; k++)
      send_frame(ACT_INSTR, 2'($urandom), 5'(k), $urandom, FRAME_LEN, 0);
    repeat (3) tick();
    chk("t2_ready_low", 64'(ready_waits), 64'(30));
    chk("t2_frame_cnt", 64'(frame_cnt), 64'(31));

    // Partial frame then timeout; the next frame must still issue.
    send_frame(4'h2, 2'd1, 5'd9, 32'h12345678, 3, 0);
    err_due = cyc + T;
    repeat (T + 3) tick();
    send_frame(4'h5, 2'd2, 5'd17, 32'hCAFEF00D, FRAME_LEN, 0);
    repeat (3) tick();
    chk("t3_frame_cnt", 64'(frame_cnt), 64'(32));

    // END frame, then an INSTR frame still issues.
    send_frame(ACT_END, 2'd0, 5'd0, $urandom, FRAME_LEN, 0);
    repeat (3) tick();
    chk("t4_done", 64'(done), 64'(1));
    chk("t4_frame_cnt", 64'(frame_cnt), 64'(32));
    send_frame(ACT_INSTR, 2'd3, 5'd31, 32'h0BADBEEF, FRAME_LEN, 1);
    repeat (3) tick();
    chk("t4_done_sticky", 64'(done), 64'(1));
    chk("t4_frame_cnt2", 64'(frame_cnt), 64'(33));

    // Reset in the middle of a frame.
    send_frame(4'h2, 2'd1, 5'd4, 32'h55AA55AA, 4, 0);
    do_reset();
    chk_reset_state("t5");
    send_frame(4'h3, 2'd2, 5'd6, 32'h89ABCDEF, FRAME_LEN, 0);
    repeat (3) tick();
    chk("t5_frame_cnt", 64'(frame_cnt), 64'(1));

    // 256 issued frames wrap the frame counter.
    do_reset();
    for (int k = 0; k < 256; k++)
      send_frame(4'($urandom_range(1, 14)), 2'($urandom), 5'($urandom), $urandom, FRAME_LEN, 0);
    repeat (3) tick();
    chk("t6_wrap", 64'(frame_cnt), 64'(0));

    // Every byte lands on the cycle the timeout would fire.
    send_frame(4'h3, 2'd1, 5'd7, 32'hA5A5F00F, FRAME_LEN, T - 1);
    repeat (3) tick();
    chk("t6_edge_frame_cnt", 64'(frame_cnt), 64'(1));

    // Random mix of NOP/END/command frames with random gaps.
    for (int k = 0; k < 80; k++)
      send_frame(4'($urandom), 2'($urandom), 5'($urandom), $urandom, FRAME_LEN, -1);
    repeat (4) tick();
    chk("q_drained", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
